// File: rtl/hilo_mdu.sv
// rtl/hilo_mdu.sv - HI/LO result registers with a 33-cycle restoring divider
module hilo_mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] OP_MULT_LOAD = 3'b000;
    localparam logic [2:0] OP_MTHI      = 3'b001;
    localparam logic [2:0] OP_MTLO      = 3'b010;
    localparam logic [2:0] OP_DIV       = 3'b100;
    localparam logic [2:0] OP_DIVU      = 3'b101;

    logic [1:0]  state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [32:0] rem_q, rem_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;

    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] rem_shift;
    logic [33:0] diff;

    // dvd_q shifts the dividend out of its MSB while quotient bits enter at the LSB
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        abs_a     = a[31] ? (32'd0 - a) : a;
        abs_b     = b[31] ? (32'd0 - b) : b;
        rem_shift = {rem_q[31:0], dvd_q[31]};
        diff      = {1'b0, rem_shift} - {2'b00, dvs_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT_LOAD: begin
                            hi_d = alu_hi;
                            lo_d = alu_lo;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        OP_DIV: begin
                            dvd_d     = abs_a;
                            dvs_d     = abs_b;
                            neg_rem_d = a[31];
                            neg_quo_d = a[31] ^ b[31];
                            rem_d     = 33'd0;
                            cnt_d     = 5'd0;
                            state_d   = S_DIV;
                        end
                        OP_DIVU: begin
                            dvd_d     = a;
                            dvs_d     = b;
                            neg_rem_d = 1'b0;
                            neg_quo_d = 1'b0;
                            rem_d     = 33'd0;
                            cnt_d     = 5'd0;
                            state_d   = S_DIV;
                        end
                        default: ;
                    endcase
                end
            end
            S_DIV: begin
                if (!diff[33]) begin
                    rem_d = diff[32:0];
                    dvd_d = {dvd_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_shift;
                    dvd_d = {dvd_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                lo_d    = neg_quo_q ? (32'd0 - dvd_q) : dvd_q;
                hi_d    = neg_rem_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
            cnt_q     <= 5'd0;
            dvd_q     <= 32'd0;
            dvs_q     <= 32'd0;
            rem_q     <= 33'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// tb/tb_hilo_mdu.sv - directed scoreboard bench for hilo_mdu
module tb_hilo_mdu;

    localparam logic [2:0] OP_MULT_LOAD = 3'b000;
    localparam logic [2:0] OP_MTHI      = 3'b001;
    localparam logic [2:0] OP_MTLO      = 3'b010;
    localparam logic [2:0] OP_DIV       = 3'b100;
    localparam logic [2:0] OP_DIVU      = 3'b101;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b, alu_hi, alu_lo;
    logic [31:0] hi, lo;
    logic        busy, done;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    hilo_mdu dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .alu_hi (alu_hi),
        .alu_lo (alu_lo),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Expected {hi, lo} for a divide, including the zero-divisor and overflow cases
    function automatic logic [63:0] div_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0)
            return {x, (o == OP_DIV && x[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF};
        if (o == OP_DIVU)
            return {x % y, x / y};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            return {32'h0, 32'h8000_0000};
        return {32'($signed(x) % $signed(y)), 32'($signed(x) / $signed(y))};
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] ah,
                          input logic [31:0] al, input logic [31:0] eh, input logic [31:0] el,
                          input string tag);
        logic [63:0] e;
        sb.push_back({eh, el});
        @(negedge clk);
        start = 1'b1; op = o; a = av; alu_hi = ah; alu_lo = al;
        @(negedge clk);
        start = 1'b0; alu_hi = $urandom; alu_lo = $urandom;
        e = sb.pop_front();
        chk({tag, "_hi"}, hi, e[63:32]);
        chk({tag, "_lo"}, lo, e[31:0]);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    task automatic run_div(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                           input int inj, input int rst_at, input string tag);
        logic [63:0] e;
        int n;
        int pulses;
        bit aborted;
        aborted = 1'b0;
        sb.push_back(div_model(o, av, bv));
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == inj) begin
                start = 1'b1; op = OP_MTHI; a = 32'd5;
            end
            if (n == rst_at) reset = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (reset) begin
                chk({tag, "_rst_hi"}, hi, 32'd0);
                chk({tag, "_rst_lo"}, lo, 32'd0);
                chk({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
                reset = 1'b0;
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) begin
            void'(sb.pop_front());
            pulses = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done === 1'b1) pulses++;
            end
            chk({tag, "_no_done"}, 32'(pulses), 32'd0);
        end else begin
            chk({tag, "_busy_cycles"}, 32'(n), 32'd33);
            chk({tag, "_done"}, {31'd0, done}, 32'd1);
            e = sb.pop_front();
            chk({tag, "_hi"}, hi, e[63:32]);
            chk({tag, "_lo"}, lo, e[31:0]);
            @(negedge clk);
            chk({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'b000;
        a = 32'd0; b = 32'd0; alu_hi = 32'd0; alu_lo = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);

        run_op(OP_MTHI, 32'h1234_5678, 32'h0, 32'h0, 32'h1234_5678, 32'h0, "mthi");
        run_op(OP_MTLO, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h1234_5678, 32'hCAFE_F00D, "mtlo");
        run_op(OP_MULT_LOAD, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
        run_op(3'b111, 32'hDEAD_BEEF, 32'h1, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "noop");

        run_div(OP_DIVU, 32'd100, 32'd7, 10, 0, "divu_100_7");
        run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_m7_2");
        run_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_ovf");
        run_div(OP_DIVU, 32'd9, 32'd0, 0, 0, "divu_by0");
        run_div(OP_DIV, 32'hFFFF_FFF7, 32'd0, 0, 0, "div_m9_by0");
        run_div(OP_DIV, 32'd9, 32'd0, 0, 0, "div_p9_by0");
        run_div(OP_DIVU, 32'hFFFF_FFFF, 32'd3, 0, 0, "divu_big");
        run_div(OP_DIV, 32'd100, 32'hFFFF_FFF9, 0, 0, "div_100_m7");
        run_div(OP_DIVU, 32'd100, 32'd7, 0, 15, "divu_abort");
        run_div(OP_DIVU, 32'd100, 32'd7, 0, 0, "divu_after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
